mem_region_router: RTL and testbench

//  Parametrised successor to the fixed-map MMU decoder. Routes the Vicuna/Ibex data-memory bus
//  to NUM_TGT target ports, each described by base/size/read-only parameters, with one

---
 rtl/mem_region_router.sv | 164 ++++++++++++++++
 tb/tb_mem_region_router.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_router.sv
// mem_region_router: routes the core data-memory bus to NUM_TGT address
// regions, one transaction in flight, with a per-transaction response
// timeout and an error response for unmapped or write-protected accesses.
module mem_region_router #(
  parameter int                      MEM_W       = 32,
  parameter int                      NUM_TGT     = 4,
  parameter logic [NUM_TGT*32-1:0]   TGT_BASE    = {NUM_TGT{32'h0}},
  parameter logic [NUM_TGT*32-1:0]   TGT_SIZE    = {NUM_TGT{32'h1000}},
  parameter logic [NUM_TGT-1:0]      TGT_RO      = '0,
  parameter int                      TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  // core side
  input  logic                     vproc_mem_req_o,
  input  logic [31:0]              vproc_mem_addr_o,
  input  logic                     vproc_mem_we_o,
  input  logic [MEM_W/8-1:0]       vproc_mem_be_o,
  input  logic [MEM_W-1:0]         vproc_mem_wdata_o,
  output logic                     vproc_mem_rvalid_i,
  output logic                     vproc_mem_err_i,
  output logic [MEM_W-1:0]         vproc_mem_rdata_i,
  // target side
  output logic [NUM_TGT-1:0]       tgt_req_o,
  output logic [31:0]              tgt_addr_o,
  output logic                     tgt_we_o,
  output logic [MEM_W/8-1:0]       tgt_be_o,
  output logic [MEM_W-1:0]         tgt_wdata_o,
  input  logic [NUM_TGT-1:0]       tgt_rvalid_i,
  input  logic [NUM_TGT-1:0]       tgt_err_i,
  input  logic [NUM_TGT*MEM_W-1:0] tgt_rdata_i,
  output logic                     busy_o
);

  localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [MEM_W/8-1:0] be_q, be_d;
  logic [MEM_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_W-1:0]   rdata_q, rdata_d;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic [31:0]        dec_base;
  logic [MEM_W-1:0]   sel_rdata;

  // Address decode: scan high to low so the lowest matching index wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec_hit  = 1'b0;
    dec_sel  = '0;
    dec_base = TGT_BASE[31:0];
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((vproc_mem_addr_o & ~(TGT_SIZE[i*32 +: 32] - 32'd1)) == TGT_BASE[i*32 +: 32]) begin
        dec_hit  = 1'b1;
        dec_sel  = SEL_W'(i);
        dec_base = TGT_BASE[i*32 +: 32];
      end
    end
  end

  assign sel_rdata = tgt_rdata_i[MEM_W*int'(sel_q) +: MEM_W];

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: transaction sequencing, latching and timeout counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (vproc_mem_req_o) begin
          addr_d  = vproc_mem_addr_o - dec_base;
          we_d    = vproc_mem_we_o;
          be_d    = vproc_mem_be_o;
          wdata_d = vproc_mem_wdata_o;
          sel_d   = dec_sel;
          if (dec_hit && !(vproc_mem_we_o && TGT_RO[dec_sel])) state_d = S_ISSUE;
          else                                                 state_d = S_ERR;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Error beats valid when a target raises both in the same cycle.
        if (tgt_err_i[sel_q]) begin
          state_d = S_ERR;
        end else if (tgt_rvalid_i[sel_q]) begin
          rdata_d = we_q ? '0 : sel_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and latched transaction.
  always_comb begin
    tgt_req_o          = '0;
    vproc_mem_rvalid_i = (state_q == S_RESP);
    vproc_mem_err_i    = (state_q == S_ERR);
    vproc_mem_rdata_i  = (state_q == S_RESP) ? rdata_q : '0;
    busy_o             = (state_q != S_IDLE);
    if (state_q == S_ISSUE) tgt_req_o[sel_q] = 1'b1;
  end

  assign tgt_addr_o  = addr_q;
  assign tgt_we_o    = we_q;
  assign tgt_be_o    = be_q;
  assign tgt_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: two regions (tgt1 read-only),
// four-cycle timeout, hand-computed expected values.
module tb_mem_region_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;
  logic [1:0]  tgt_req;
  logic [31:0] tgt_addr;
  logic        tgt_we;
  logic [3:0]  tgt_be;
  logic [31:0] tgt_wdata;
  logic [1:0]  tgt_rvalid;
  logic [1:0]  tgt_err;
  logic [63:0] tgt_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_region_router #(
    .MEM_W      (32),
    .NUM_TGT    (2),
    .TGT_BASE   ({32'h0000_2000, 32'h0000_1000}),
    .TGT_SIZE   ({32'h0000_1000, 32'h0000_1000}),
    .TGT_RO     (2'b10),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .vproc_mem_req_o   (req),
    .vproc_mem_addr_o  (addr),
    .vproc_mem_we_o    (we),
    .vproc_mem_be_o    (be),
    .vproc_mem_wdata_o (wdata),
    .vproc_mem_rvalid_i(rvalid),
    .vproc_mem_err_i   (err),
    .vproc_mem_rdata_i (rdata),
    .tgt_req_o         (tgt_req),
    .tgt_addr_o        (tgt_addr),
    .tgt_we_o          (tgt_we),
    .tgt_be_o          (tgt_be),
    .tgt_wdata_o       (tgt_wdata),
    .tgt_rvalid_i      (tgt_rvalid),
    .tgt_err_i         (tgt_err),
    .tgt_rdata_i       (tgt_rdata),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns in cycle 1 (tgt_req / decode-error cycle).
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    tick();
    req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    tgt_rvalid = '0; tgt_err = '0;
    tgt_rdata = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    tick(); tick();

    // Reset state
    check("rst_busy",     busy,     0);
    check("rst_rvalid",   rvalid,   0);
    check("rst_err",      err,      0);
    check("rst_tgt_req",  tgt_req,  0);
    check("rst_tgt_addr", tgt_addr, 0);
    check("rst_rdata",    rdata,    0);
    rst = 1'b1;
    tick();

    // 1: read 0x1004 from tgt0, response one cycle after tgt_req
    issue(32'h1004, 1'b0, 4'hF, 32'h0);
    check("t1_tgt_req",  tgt_req,  2'b01);
    check("t1_tgt_addr", tgt_addr, 32'h4);
    check("t1_tgt_we",   tgt_we,   0);
    check("t1_busy",     busy,     1);
    tick();                                    // cycle 2: WAIT
    check("t1_c2_rvalid",  rvalid,  0);
    check("t1_c2_tgt_req", tgt_req, 0);
    tgt_rvalid = 2'b01;
    tick();                                    // cycle 3: RESP
    tgt_rvalid = 2'b00;
    check("t1_rvalid", rvalid, 1);
    check("t1_err",    err,    0);
    check("t1_rdata",  rdata,  32'hDEAD_BEEF);
    tick();
    check("t1_done_rvalid", rvalid, 0);
    check("t1_done_busy",   busy,   0);
    check("t1_done_rdata",  rdata,  0);

    // 2: write to unmapped 0x50 -> decode error at cycle 1
    issue(32'h50, 1'b1, 4'hF, 32'h1111_2222);
    check("t2_err",     err,     1);
    check("t2_tgt_req", tgt_req, 0);
    check("t2_rvalid",  rvalid,  0);
    tick();
    check("t2_busy", busy, 0);
    check("t2_err2", err,  0);

    // 3: write to read-only region 0x2000 -> error, no target request
    issue(32'h2000, 1'b1, 4'h3, 32'h5555_AAAA);
    check("t3_err",     err,     1);
    check("t3_tgt_req", tgt_req, 0);
    tick();
    check("t3_tgt_req2", tgt_req, 0);
    check("t3_busy",     busy,    0);

    // 3b: write to writable tgt0 at 0x1008 -> rvalid with rdata 0
    issue(32'h1008, 1'b1, 4'h6, 32'hA5A5_0F0F);
    check("t3b_tgt_req",   tgt_req,   2'b01);
    check("t3b_tgt_addr",  tgt_addr,  32'h8);
    check("t3b_tgt_we",    tgt_we,    1);
    check("t3b_tgt_be",    tgt_be,    4'h6);
    check("t3b_tgt_wdata", tgt_wdata, 32'hA5A5_0F0F);
    tick();
    tgt_rvalid = 2'b01;
    tick();
    tgt_rvalid = 2'b00;
    check("t3b_rvalid", rvalid, 1);
    check("t3b_rdata",  rdata,  0);
    tick();

    // 3c: read top word of read-only tgt1; tgt0 rvalid in WAIT ignored; reply at k=4
    issue(32'h2FFC, 1'b0, 4'hF, 32'h0);
    check("t3c_tgt_req",  tgt_req,  2'b10);
    check("t3c_tgt_addr", tgt_addr, 32'hFFC);
    tick();                                    // cycle 2
    tgt_rvalid = 2'b01;
    tick();                                    // cycle 3
    tgt_rvalid = 2'b00;
    check("t3c_other_rvalid", rvalid, 0);
    check("t3c_other_err",    err,    0);
    check("t3c_busy",         busy,   1);
    tick();                                    // cycle 4
    tgt_rvalid = 2'b10;
    tick();                                    // cycle 5
    tgt_rvalid = 2'b00;
    check("t3c_rvalid", rvalid, 1);
    check("t3c_rdata",  rdata,  32'hCAFE_F00D);
    tick();

    // 4: silent target -> timeout error 5 cycles after tgt_req; late rvalid dropped
    issue(32'h1000, 1'b0, 4'hF, 32'h0);
    check("t4_tgt_req", tgt_req, 2'b01);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("t4_c%0d_err", c),  err,  0);
      check($sformatf("t4_c%0d_busy", c), busy, 1);
    end
    tick();                                    // cycle 6
    check("t4_err",    err,    1);
    check("t4_rvalid", rvalid, 0);
    tick();                                    // cycle 7: IDLE
    tgt_rvalid = 2'b01;
    check("t4_idle_busy", busy, 0);
    tick();
    tgt_rvalid = 2'b00;
    check("t4_late_rvalid", rvalid, 0);
    check("t4_late_err",    err,    0);
    check("t4_late_busy",   busy,   0);

    // 5: rvalid and err together from selected target -> err only
    issue(32'h1000, 1'b0, 4'hF, 32'h0);
    tick();
    tgt_rvalid = 2'b01; tgt_err = 2'b01;
    tick();
    tgt_rvalid = 2'b00; tgt_err = 2'b00;
    check("t5_err",    err,    1);
    check("t5_rvalid", rvalid, 0);
    check("t5_rdata",  rdata,  0);
    tick();

    // 6: reset during WAIT aborts; fresh read completes normally
    issue(32'h2004, 1'b0, 4'hF, 32'h0);
    check("t6_tgt_req", tgt_req, 2'b10);
    tick();                                    // cycle 2: WAIT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tgt_rvalid = 2'b10;
    check("t6_rst_busy",     busy,     0);
    check("t6_rst_tgt_addr", tgt_addr, 0);
    check("t6_rst_tgt_req",  tgt_req,  0);
    check("t6_rst_err",      err,      0);
    tick();
    tgt_rvalid = 2'b00;
    check("t6_no_resp", rvalid, 0);
    issue(32'h1010, 1'b0, 4'hF, 32'h0);
    check("t6_tgt_addr", tgt_addr, 32'h10);
    tick();                                    // cycle 2
    tick();                                    // cycle 3
    tgt_rvalid = 2'b01;
    tgt_rdata  = {32'h0, 32'h1357_9BDF};
    tick();                                    // cycle 4
    tgt_rvalid = 2'b00;
    check("t6_rvalid", rvalid, 1);
    check("t6_rdata",  rdata,  32'h1357_9BDF);
    tick();
    check("t6_done_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
